// File: rtl/hp_bar_mmr.sv
// BAR0 Avalon-MM slave to single-beat register bus bridge, one access in flight; waitrequest low k+2 cycles
// after command (ack k cycles after strobe), readdatavalid at k+3; host held off by waitrequest, timeout forces completion.
module hp_bar_mmr #(
   parameter int          AW       = 12,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic          sysclk,
   input  logic          rst_n,
   input  logic [AW-1:0] avs_address,
   input  logic          avs_read,
   input  logic          avs_write,
   input  logic [31:0]   avs_writedata,
   input  logic [3:0]    avs_byteenable,
   output logic          avs_waitrequest,
   output logic [31:0]   avs_readdata,
   output logic          avs_readdatavalid,
   output logic [AW-3:0] reg_addr,
   output logic          reg_wr,
   output logic          reg_rd,
   output logic [31:0]   reg_wdata,
   output logic [3:0]    reg_be,
   input  logic [31:0]   reg_rdata,
   input  logic          reg_ack,
   output logic [15:0]   timeout_cnt
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, RESP} state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [15:0]   wait_cnt, wait_nxt;
   logic          is_rd, is_rd_nxt;
   logic [AW-3:0] addr_nxt;
   logic [31:0]   wdata_nxt;
   logic [3:0]    be_nxt;
   logic          wr_nxt, rd_nxt, wreq_nxt, rdv_nxt;
   logic [31:0]   rdata_nxt;
   logic [15:0]   tcnt_nxt;

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      is_rd_nxt = is_rd;
      addr_nxt  = reg_addr;
      wdata_nxt = reg_wdata;
      be_nxt    = reg_be;
      wr_nxt    = 1'b0;
      rd_nxt    = 1'b0;
      wreq_nxt  = 1'b1;
      rdv_nxt   = 1'b0;
      rdata_nxt = avs_readdata;
      tcnt_nxt  = timeout_cnt;
      case (state)
         IDLE: begin
            // A simultaneous read and write is illegal; the write wins.
            if (avs_write || avs_read) begin
               addr_nxt  = avs_address[AW-1:2];
               wdata_nxt = avs_writedata;
               be_nxt    = avs_byteenable;
               is_rd_nxt = !avs_write;
               wr_nxt    = avs_write;
               rd_nxt    = !avs_write;
               wait_nxt  = 16'd0;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (reg_ack) begin
               if (is_rd) rdata_nxt = reg_rdata;
               wreq_nxt  = 1'b0;
               state_nxt = DONE;
            end else if (wait_cnt == WAIT_LAST) begin
               if (is_rd) rdata_nxt = ERR_DATA;
               if (timeout_cnt != 16'hFFFF) tcnt_nxt = timeout_cnt + 16'd1;
               wreq_nxt  = 1'b0;
               state_nxt = DONE;
            end else begin
               wait_nxt = wait_cnt + 16'd1;
            end
         end
         DONE: begin
            rdv_nxt   = is_rd;
            state_nxt = is_rd ? RESP : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state             <= IDLE;
         wait_cnt          <= 16'd0;
         is_rd             <= 1'b0;
         reg_addr          <= '0;
         reg_wdata         <= 32'd0;
         reg_be            <= 4'd0;
         reg_wr            <= 1'b0;
         reg_rd            <= 1'b0;
         avs_waitrequest   <= 1'b1;
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= 32'd0;
         timeout_cnt       <= 16'd0;
      end else begin
         state             <= state_nxt;
         wait_cnt          <= wait_nxt;
         is_rd             <= is_rd_nxt;
         reg_addr          <= addr_nxt;
         reg_wdata         <= wdata_nxt;
         reg_be            <= be_nxt;
         reg_wr            <= wr_nxt;
         reg_rd            <= rd_nxt;
         avs_waitrequest   <= wreq_nxt;
         avs_readdatavalid <= rdv_nxt;
         avs_readdata      <= rdata_nxt;
         timeout_cnt       <= tcnt_nxt;
      end
   end

endmodule

// File: tb/tb_hp_bar_mmr.sv
// Directed bench for hp_bar_mmr: inputs driven and outputs sampled on the falling edge.
module tb_hp_bar_mmr;

   logic        sysclk = 1'b0;
   logic        rst_n;
   logic [11:0] avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_waitrequest;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic [9:0]  reg_addr;
   logic        reg_wr, reg_rd;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic [15:0] timeout_cnt;

   int tests = 0;
   int fails = 0;

   // Per-access observations
   int          wr_n, rd_n, rdv_n, wlow_n, wlow_at, rdv_at;
   logic [31:0] got_data, strobe_addr, strobe_wdata, strobe_be;

   always #5 sysclk = ~sysclk;

   hp_bar_mmr dut (
      .sysclk(sysclk), .rst_n(rst_n),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
      .reg_ack(reg_ack), .timeout_cnt(timeout_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one command and acks ack_at cycles after the strobe (strobe cycle = 0, -1 = never).
   task automatic run_access(input logic w, input logic r, input logic [11:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             input int ack_at, input logic [31:0] sdata);
      avs_write = w; avs_read = r; avs_address = a; avs_writedata = d; avs_byteenable = be;
      wr_n = 0; rd_n = 0; rdv_n = 0; wlow_n = 0; wlow_at = -1; rdv_at = -1;
      got_data = 32'd0; strobe_addr = 32'd0; strobe_wdata = 32'd0; strobe_be = 32'd0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge sysclk);
         reg_ack = 1'b0;
         if (reg_wr || reg_rd) begin
            strobe_addr  = 32'(reg_addr);
            strobe_wdata = reg_wdata;
            strobe_be    = 32'(reg_be);
         end
         if (reg_wr) wr_n++;
         if (reg_rd) rd_n++;
         if (!avs_waitrequest) begin
            wlow_n++;
            if (wlow_at < 0) wlow_at = c;
            avs_write = 1'b0;
            avs_read  = 1'b0;
         end
         if (avs_readdatavalid) begin
            rdv_n++;
            rdv_at   = c;
            got_data = avs_readdata;
         end
         if (ack_at >= 0 && c == ack_at + 1) begin
            reg_ack   = 1'b1;
            reg_rdata = sdata;
         end
         if (wlow_at > 0 && c >= wlow_at + 3) break;
      end
      reg_ack   = 1'b0;
      avs_write = 1'b0;
      avs_read  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; avs_address = 12'd0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = 32'd0; avs_byteenable = 4'd0; reg_rdata = 32'd0; reg_ack = 1'b0;
      repeat (3) @(negedge sysclk);

      check("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
      check("rst_readdatavalid", 32'(avs_readdatavalid), 32'd0);
      check("rst_readdata", avs_readdata, 32'd0);
      check("rst_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge sysclk);

      // Write, ack two cycles after strobe
      run_access(1'b1, 1'b0, 12'h100, 32'hA5A5_1234, 4'hF, 2, 32'hFFFF_FFFF);
      check("t1_wr_pulses", 32'(wr_n), 32'd1);
      check("t1_rd_pulses", 32'(rd_n), 32'd0);
      check("t1_reg_addr", strobe_addr, 32'h40);
      check("t1_reg_wdata", strobe_wdata, 32'hA5A5_1234);
      check("t1_reg_be", strobe_be, 32'hF);
      check("t1_wreq_low_at", 32'(wlow_at), 32'd4);
      check("t1_wreq_low_count", 32'(wlow_n), 32'd1);
      check("t1_rdv_count", 32'(rdv_n), 32'd0);

      // Read with zero-wait ack in the strobe cycle
      run_access(1'b0, 1'b1, 12'h004, 32'd0, 4'hF, 0, 32'h0BAD_F00D);
      check("t2_rd_pulses", 32'(rd_n), 32'd1);
      check("t2_reg_addr", strobe_addr, 32'h1);
      check("t2_wreq_low_at", 32'(wlow_at), 32'd2);
      check("t2_rdv_at", 32'(rdv_at), 32'd3);
      check("t2_rdv_count", 32'(rdv_n), 32'd1);
      check("t2_readdata", got_data, 32'h0BAD_F00D);

      // Read with no ack: timeout
      check("t3_tcnt_before", 32'(timeout_cnt), 32'd0);
      run_access(1'b0, 1'b1, 12'h008, 32'd0, 4'hF, -1, 32'd0);
      check("t3_wreq_low_at", 32'(wlow_at), 32'd256);
      check("t3_rdv_at", 32'(rdv_at), 32'd257);
      check("t3_readdata", got_data, 32'hDEAD_BEEF);
      check("t3_tcnt_after", 32'(timeout_cnt), 32'd1);

      // Ack in the last timeout cycle wins
      run_access(1'b0, 1'b1, 12'h00C, 32'd0, 4'hF, 254, 32'h1234_5678);
      check("t4_wreq_low_at", 32'(wlow_at), 32'd256);
      check("t4_readdata", got_data, 32'h1234_5678);
      check("t4_tcnt", 32'(timeout_cnt), 32'd1);

      // Read and write together: write only
      run_access(1'b1, 1'b1, 12'h010, 32'hCAFE_0001, 4'h3, 0, 32'h5555_5555);
      check("t5_wr_pulses", 32'(wr_n), 32'd1);
      check("t5_rd_pulses", 32'(rd_n), 32'd0);
      check("t5_rdv_count", 32'(rdv_n), 32'd0);
      check("t5_wreq_low_at", 32'(wlow_at), 32'd2);
      check("t5_reg_be", strobe_be, 32'h3);

      // Reset pulse in the middle of an ACCESS
      avs_read = 1'b1; avs_address = 12'h020;
      repeat (3) @(negedge sysclk);
      rst_n = 1'b0; avs_read = 1'b0;
      @(negedge sysclk);
      check("t6_rst_waitrequest", 32'(avs_waitrequest), 32'd1);
      check("t6_rst_readdatavalid", 32'(avs_readdatavalid), 32'd0);
      check("t6_rst_reg_addr", 32'(reg_addr), 32'd0);
      check("t6_rst_tcnt", 32'(timeout_cnt), 32'd0);
      rst_n = 1'b1;
      rdv_n = 0; wlow_n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge sysclk);
         if (avs_readdatavalid) rdv_n++;
         if (!avs_waitrequest || reg_rd || reg_wr) wlow_n++;
      end
      check("t6_no_rdv_after_abort", 32'(rdv_n), 32'd0);
      check("t6_no_activity_after_abort", 32'(wlow_n), 32'd0);
      run_access(1'b0, 1'b1, 12'h024, 32'd0, 4'hF, 1, 32'h600D_DA7A);
      check("t6_wreq_low_at", 32'(wlow_at), 32'd3);
      check("t6_rdv_at", 32'(rdv_at), 32'd4);
      check("t6_readdata", got_data, 32'h600D_DA7A);
      check("t6_reg_addr", strobe_addr, 32'h9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
